// File: rtl/stopwatch_display_mux.sv
// Four-digit MM.SS seven-segment scanner with per-frame tear-free snapshot of the count.
// Define DISP_BLINK_EN to blink the field selected for adjustment.
module stopwatch_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] refresh_cnt_reg;
  logic [1:0]    digit_idx_reg;
  logic [5:0]    min_sync1_reg, min_sync2_reg, sec_sync1_reg, sec_sync2_reg;
  logic [5:0]    min_snap_reg, sec_snap_reg;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic          refresh_wrap, load_strobe, blank;

  assign refresh_wrap = (refresh_cnt_reg == RW'(REFRESH_DIV - 1));
  assign load_strobe  = (refresh_cnt_reg == '0) && (digit_idx_reg == 2'd0);

  function automatic logic [5:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50)      tens_of = 6'd5;
    else if (v >= 6'd40) tens_of = 6'd4;
    else if (v >= 6'd30) tens_of = 6'd3;
    else if (v >= 6'd20) tens_of = 6'd2;
    else if (v >= 6'd10) tens_of = 6'd1;
    else                 tens_of = 6'd0;
  endfunction

  function automatic logic [6:0] seg_of(input logic [5:0] d);
    case (d)
      6'd0:    seg_of = 7'h40;
      6'd1:    seg_of = 7'h79;
      6'd2:    seg_of = 7'h24;
      6'd3:    seg_of = 7'h30;
      6'd4:    seg_of = 7'h19;
      6'd5:    seg_of = 7'h12;
      6'd6:    seg_of = 7'h02;
      6'd7:    seg_of = 7'h78;
      6'd8:    seg_of = 7'h00;
      6'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  // Scan counters, synchronisers and the frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= 2'd0;
      min_sync1_reg   <= '0;
      min_sync2_reg   <= '0;
      sec_sync1_reg   <= '0;
      sec_sync2_reg   <= '0;
      min_snap_reg    <= '0;
      sec_snap_reg    <= '0;
    end else begin
      min_sync1_reg <= minutes;
      min_sync2_reg <= min_sync1_reg;
      sec_sync1_reg <= seconds;
      sec_sync2_reg <= sec_sync1_reg;
      if (refresh_wrap) begin
        refresh_cnt_reg <= '0;
        digit_idx_reg   <= digit_idx_reg + 2'd1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
      end
      // A field still settling through its synchroniser keeps last frame's value
      if (load_strobe && (min_sync1_reg == min_sync2_reg)) min_snap_reg <= min_sync2_reg;
      if (load_strobe && (sec_sync1_reg == sec_sync2_reg)) sec_snap_reg <= sec_sync2_reg;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;
  logic          adj_sync1_reg, adj_sync2_reg, sel_sync1_reg, sel_sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      adj_sync1_reg   <= 1'b0;
      adj_sync2_reg   <= 1'b0;
      sel_sync1_reg   <= 1'b0;
      sel_sync2_reg   <= 1'b0;
    end else begin
      adj_sync1_reg <= adj;
      adj_sync2_reg <= adj_sync1_reg;
      sel_sync1_reg <= sel;
      sel_sync2_reg <= sel_sync1_reg;
      if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BW'(1);
      end
    end
  end

  // digit_idx[1] distinguishes the minutes digits (2,3) from the seconds digits (0,1)
  assign blank = adj_sync2_reg && blink_phase_reg &&
                 (sel_sync2_reg ? ~digit_idx_reg[1] : digit_idx_reg[1]);
`else
  logic unused_blink_inputs;
  assign unused_blink_inputs = &{1'b0, adj, sel};
  assign blank = 1'b0;
`endif

  always_comb begin
    logic [5:0] field_val;
    logic [5:0] tens;
    logic [5:0] ones;
    field_val = digit_idx_reg[1] ? min_snap_reg : sec_snap_reg;
    tens      = tens_of(field_val);
    ones      = field_val - (tens * 6'd10);
    an_next   = ~(4'b0001 << digit_idx_reg);
    seg_next  = seg_of(digit_idx_reg[0] ? tens : ones);
    dp_next   = (digit_idx_reg != 2'd2);
    if (field_val >= 6'd60) seg_next = 7'h3F;
    if (blank)              an_next  = 4'b1111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Directed bench for stopwatch_display_mux: vector table of MM:SS values plus scan, tear-free and blink sequences.
module tb_stopwatch_display_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  stopwatch_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .reset(reset), .minutes(minutes), .seconds(seconds),
    .adj(adj), .sel(sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]       m;
    logic [5:0]       s;
    logic [3:0][6:0]  segs;   // index = digit position
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic goto(input int e);
    int guard = 0;
    while (cyc < e && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != e) begin
      checks++;
      errors++;
      $display("FAIL goto cyc got %0d want %0d", cyc, e);
    end
  endtask

  task automatic restart(input logic [5:0] m, input logic [5:0] s, input logic a, input logic sl);
    @(negedge clk);
    reset   = 1'b1;
    minutes = m;
    seconds = s;
    adj     = a;
    sel     = sl;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_digit(input string tag, input int d, input logic [6:0] exp_seg);
    logic [3:0] ea;
    ea = ~(4'b0001 << d);
    check($sformatf("%s d%0d an", tag, d), {3'b0, an}, {3'b0, ea});
    check($sformatf("%s d%0d seg", tag, d), seg, exp_seg);
    check($sformatf("%s d%0d dp", tag, d), {6'b0, dp}, {6'b0, (d != 2)});
  endtask

  task automatic check_an(input string tag, input logic [3:0] exp_an);
    check(tag, {3'b0, an}, {3'b0, exp_an});
  endtask

  initial begin
    int blanked;
    vecs[0] = '{m: 6'd12, s: 6'd34, segs: {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{m: 6'd63, s: 6'd60, segs: {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[2] = '{m: 6'd59, s: 6'd59, segs: {7'h12, 7'h10, 7'h12, 7'h10}};
    vecs[3] = '{m: 6'd0,  s: 6'd0,  segs: {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{m: 6'd10, s: 6'd9,  segs: {7'h79, 7'h40, 7'h40, 7'h10}};
    vecs[5] = '{m: 6'd45, s: 6'd16, segs: {7'h19, 7'h12, 7'h79, 7'h02}};
    vecs[6] = '{m: 6'd60, s: 6'd59, segs: {7'h3F, 7'h3F, 7'h12, 7'h10}};
    vecs[7] = '{m: 6'd38, s: 6'd62, segs: {7'h30, 7'h00, 7'h3F, 7'h3F}};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset an", {3'b0, an}, 7'h0F);
    check("reset seg", seg, 7'h7F);
    check("reset dp", {6'b0, dp}, 7'h01);

    // Vector table: second frame, middle of each digit slot
    for (int i = 0; i < 8; i++) begin
      restart(vecs[i].m, vecs[i].s, 1'b0, 1'b0);
      for (int d = 0; d < 4; d++) begin
        goto(19 + 4 * d);
        check_digit($sformatf("vec%0d %0d:%0d", i, vecs[i].m, vecs[i].s), d, vecs[i].segs[d]);
      end
    end

    // Asynchronous reset mid-scan, then first digit one cycle after release
    #2 reset = 1'b1;
    #1;
    check("midscan reset an", {3'b0, an}, 7'h0F);
    check("midscan reset seg", seg, 7'h7F);
    check("midscan reset dp", {6'b0, dp}, 7'h01);
    @(negedge clk);
    reset = 1'b0;
    goto(1);
    check_an("first digit after release an", 4'b1110);
    check("first digit after release seg", seg, 7'h40);

    // Scan order and hold time: every cycle of the second frame
    restart(6'd12, 6'd34, 1'b0, 1'b0);
    for (int e = 17; e <= 32; e++) begin
      int d;
      goto(e);
      d = ((e - 1) / 4) % 4;
      check_an($sformatf("scan cyc%0d an", e), ~(4'b0001 << d));
      check($sformatf("scan cyc%0d dp", e), {6'b0, dp}, {6'b0, (d != 2)});
    end

    // Tear-free update, then an input changing right at the load strobe
    restart(6'd12, 6'd34, 1'b0, 1'b0);
    goto(22);
    seconds = 6'd35;
    goto(23);
    check_digit("tear same frame", 1, 7'h30);
    goto(27);
    check_digit("tear same frame", 2, 7'h24);
    goto(31);
    check_digit("tear same frame", 3, 7'h79);
    goto(35);
    check_digit("tear next frame", 0, 7'h12);
    goto(47);
    seconds = 6'd47;
    goto(51);
    check_digit("unstable at strobe holds", 0, 7'h12);
    goto(67);
    check_digit("unstable next frame", 0, 7'h78);

`ifdef DISP_BLINK_EN
    restart(6'd12, 6'd34, 1'b1, 1'b1);
    goto(19); check_an("blink sel1 d0 an", 4'b1111);
    goto(23); check_an("blink sel1 d1 an", 4'b1111);
    goto(27); check_an("blink sel1 d2 an", 4'b1011);
    goto(31); check_an("blink sel1 d3 an", 4'b0111);
    goto(35); check_an("blink phase0 d0 an", 4'b1110);
    goto(40);
    sel = 1'b0;
    goto(51); check_an("blink sel0 d0 an", 4'b1110);
    goto(55); check_an("blink sel0 d1 an", 4'b1101);
    goto(59); check_an("blink sel0 d2 an", 4'b1111);
    goto(63); check_an("blink sel0 d3 an", 4'b1111);
    goto(66);
    adj = 1'b0;
    goto(83); check_an("blink adj0 d0 an", 4'b1110);
    goto(87); check_an("blink adj0 d1 an", 4'b1101);
    goto(91); check_an("blink adj0 d2 an", 4'b1011);
    goto(95); check_an("blink adj0 d3 an", 4'b0111);
`else
    restart(6'd12, 6'd34, 1'b1, 1'b1);
    blanked = 0;
    for (int e = 1; e <= 200; e++) begin
      goto(e);
      if (an == 4'b1111) blanked++;
    end
    check("no blink blanked cycles", 7'(blanked), 7'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
